// File: rtl/start_screen_anim.sv
// Start screen for the 96x64 RGB565 OLED: coloured wires, blinking title, wire
// selection cursor and a confirm flash that ends in a one-cycle start_game pulse.
module start_screen_anim #(
    parameter int NUM_WIRES      = 5,
    parameter int WIRE_X0        = 3,
    parameter int WIRE_PITCH     = 6,
    parameter int WIRE_W         = 2,
    parameter int CURSOR_Y0      = 58,
    parameter int BLINK_FRAMES   = 30,
    parameter int CONFIRM_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic        title_px,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        restart,
    output logic [15:0] pixel_data,
    output logic [2:0]  sel_wire,
    output logic        start_game,
    output logic        screen_active
);

    typedef enum logic [1:0] {
        ST_ATTRACT,
        ST_SELECT,
        ST_CONFIRM,
        ST_DONE
    } state_t;

    localparam int              CNT_W        = 16;
    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_FRAMES - 1);
    localparam logic [2:0]       SEL_LAST     = 3'(NUM_WIRES - 1);

    state_t           state_q, state_d;
    logic [2:0]       sel_wire_q, sel_wire_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             title_visible_q, title_visible_d;
    logic             btn_left_q, btn_right_q, btn_start_q;
    logic [15:0]      pixel_data_q, pixel_data_d;
    logic             start_game_q, start_game_d;
    logic             screen_active_q, screen_active_d;

    logic             left_edge, right_edge, start_edge, any_edge;
    logic             hit_valid, sel_hit, cursor_row;
    logic [2:0]       hit_idx;

    function automatic logic [15:0] wire_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFC0D;
            3'd1:    return 16'hF800;
            3'd2:    return 16'h001F;
            3'd3:    return 16'hFD20;
            3'd4:    return 16'h07E0;
            3'd5:    return 16'hFFE0;
            3'd6:    return 16'h07FF;
            default: return 16'h801F;
        endcase
    endfunction

    function automatic logic in_wire(input logic [6:0] px, input int idx);
        int left;
        left = WIRE_X0 + idx * WIRE_PITCH;
        return (int'(px) >= left) && (int'(px) <= left + WIRE_W - 1);
    endfunction

    assign left_edge  = btn_left  & ~btn_left_q;
    assign right_edge = btn_right & ~btn_right_q;
    assign start_edge = btn_start & ~btn_start_q;
    assign any_edge   = left_edge | right_edge | start_edge;

    // Pixel path: lowest-index wire wins if wires ever overlap.
    always_comb begin
        hit_valid = 1'b0;
        hit_idx   = 3'd0;
        for (int i = NUM_WIRES - 1; i >= 0; i--) begin
            if (in_wire(x, i)) begin
                hit_valid = 1'b1;
                hit_idx   = 3'(i);
            end
        end
        sel_hit    = in_wire(x, int'(sel_wire_q));
        cursor_row = int'(y) >= CURSOR_Y0;

        pixel_data_d = 16'h0000;
        if (state_q == ST_DONE) begin
            pixel_data_d = 16'h0000;
        end else if (title_px && title_visible_q) begin
            pixel_data_d = 16'hFFFF;
        end else if (state_q == ST_SELECT && sel_hit && cursor_row) begin
            pixel_data_d = 16'hFFFF;
        end else if (state_q == ST_CONFIRM && sel_hit) begin
            pixel_data_d = frame_cnt_q[2] ? 16'h0000 : wire_colour(sel_wire_q);
        end else if (hit_valid) begin
            pixel_data_d = wire_colour(hit_idx);
        end
    end

    always_comb begin
        state_d         = state_q;
        sel_wire_d      = sel_wire_q;
        blink_cnt_d     = blink_cnt_q;
        frame_cnt_d     = frame_cnt_q;
        title_visible_d = title_visible_q;
        start_game_d    = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
                if (frame_tick) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d     = '0;
                        title_visible_d = ~title_visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + CNT_W'(1);
                    end
                end
                // The waking press only leaves attract mode; it does not move the cursor.
                if (any_edge) begin
                    state_d         = ST_SELECT;
                    title_visible_d = 1'b1;
                end
            end
            ST_SELECT: begin
                if (start_edge) begin
                    state_d     = ST_CONFIRM;
                    frame_cnt_d = '0;
                end else if (right_edge && !left_edge) begin
                    sel_wire_d = (sel_wire_q == SEL_LAST) ? 3'd0 : sel_wire_q + 3'd1;
                end else if (left_edge && !right_edge) begin
                    sel_wire_d = (sel_wire_q == 3'd0) ? SEL_LAST : sel_wire_q - 3'd1;
                end
            end
            ST_CONFIRM: begin
                if (frame_tick) begin
                    if (frame_cnt_q == CONFIRM_LAST) begin
                        start_game_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (restart) begin
                    state_d         = ST_ATTRACT;
                    blink_cnt_d     = '0;
                    frame_cnt_d     = '0;
                    title_visible_d = 1'b1;
                end
            end
        endcase

        screen_active_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_ATTRACT;
            sel_wire_q      <= 3'd0;
            blink_cnt_q     <= '0;
            frame_cnt_q     <= '0;
            title_visible_q <= 1'b1;
            btn_left_q      <= 1'b0;
            btn_right_q     <= 1'b0;
            btn_start_q     <= 1'b0;
            pixel_data_q    <= 16'h0000;
            start_game_q    <= 1'b0;
            screen_active_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            sel_wire_q      <= sel_wire_d;
            blink_cnt_q     <= blink_cnt_d;
            frame_cnt_q     <= frame_cnt_d;
            title_visible_q <= title_visible_d;
            btn_left_q      <= btn_left;
            btn_right_q     <= btn_right;
            btn_start_q     <= btn_start;
            pixel_data_q    <= pixel_data_d;
            start_game_q    <= start_game_d;
            screen_active_q <= screen_active_d;
        end
    end

    assign pixel_data    = pixel_data_q;
    assign sel_wire      = sel_wire_q;
    assign start_game    = start_game_q;
    assign screen_active = screen_active_q;

endmodule

// File: tb/tb_start_screen_anim.sv
// Bench for start_screen_anim: directed walk through the screen flow on a 5-wire
// and an 8-wire instance, then random stimulus against a behavioural model.
module tb_start_screen_anim;

    localparam int BLINK   = 30;
    localparam int CONFIRM = 16;
    localparam int M_ATTRACT = 0, M_SELECT = 1, M_CONFIRM = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, title_px, btn_left, btn_right, btn_start, restart;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] pix5, pix8;
    logic [2:0]  sel5, sel8;
    logic        sg5, sg8, sa5, sa8;

    int n_tests = 0;
    int n_fail  = 0;
    bit saw_sg  = 1'b0;

    logic [15:0] pal [8] = '{16'hFC0D, 16'hF800, 16'h001F, 16'hFD20,
                             16'h07E0, 16'hFFE0, 16'h07FF, 16'h801F};
    int          nw  [2] = '{5, 8};

    int          m_mode [2];
    int          m_sel  [2];
    int          m_blink[2];
    int          m_frame[2];
    bit          m_tv   [2];
    logic [15:0] e_pix  [2];
    bit          e_sg   [2];
    bit          e_sa   [2];
    bit          pl, pr, ps;

    always #5 clk = ~clk;

    start_screen_anim u_dut5 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .x(x), .y(y),
        .title_px(title_px), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .restart(restart), .pixel_data(pix5),
        .sel_wire(sel5), .start_game(sg5), .screen_active(sa5)
    );

    start_screen_anim #(.NUM_WIRES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .x(x), .y(y),
        .title_px(title_px), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .restart(restart), .pixel_data(pix8),
        .sel_wire(sel8), .start_game(sg8), .screen_active(sa8)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit on_wire(int xx, int idx);
        return (xx >= 3 + idx * 6) && (xx < 3 + idx * 6 + 2);
    endfunction

    function automatic logic [15:0] model_pix(int k, int xx, int yy, bit tp);
        int hit;
        hit = -1;
        if (m_mode[k] == M_DONE) return 16'h0000;
        if (tp && m_tv[k]) return 16'hFFFF;
        for (int i = 0; i < nw[k]; i++)
            if (hit < 0 && on_wire(xx, i)) hit = i;
        if (m_mode[k] == M_SELECT && on_wire(xx, m_sel[k]) && yy >= 58) return 16'hFFFF;
        if (m_mode[k] == M_CONFIRM && on_wire(xx, m_sel[k]))
            return ((m_frame[k] / 4) % 2 == 1) ? 16'h0000 : pal[m_sel[k]];
        if (hit >= 0) return pal[hit];
        return 16'h0000;
    endfunction

    task automatic model_step();
        bit le, re, se;
        le = btn_left && !pl;
        re = btn_right && !pr;
        se = btn_start && !ps;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_mode[k] = M_ATTRACT; m_sel[k] = 0; m_blink[k] = 0; m_frame[k] = 0;
                m_tv[k] = 1'b1; e_pix[k] = 16'h0000; e_sg[k] = 1'b0;
            end else begin
                e_pix[k] = model_pix(k, int'(x), int'(y), title_px);
                e_sg[k]  = 1'b0;
                case (m_mode[k])
                    M_ATTRACT: begin
                        if (frame_tick) begin
                            m_blink[k] = (m_blink[k] + 1) % BLINK;
                            if (m_blink[k] == 0) m_tv[k] = !m_tv[k];
                        end
                        if (le || re || se) begin
                            m_mode[k] = M_SELECT;
                            m_tv[k]   = 1'b1;
                        end
                    end
                    M_SELECT: begin
                        if (se) begin
                            m_mode[k] = M_CONFIRM; m_frame[k] = 0;
                        end else if (re && !le) begin
                            m_sel[k] = (m_sel[k] + 1) % nw[k];
                        end else if (le && !re) begin
                            m_sel[k] = (m_sel[k] + nw[k] - 1) % nw[k];
                        end
                    end
                    M_CONFIRM: begin
                        if (frame_tick) begin
                            if (m_frame[k] == CONFIRM - 1) begin
                                e_sg[k] = 1'b1; m_mode[k] = M_DONE;
                            end else begin
                                m_frame[k]++;
                            end
                        end
                    end
                    default: begin
                        if (restart) begin
                            m_mode[k] = M_ATTRACT; m_blink[k] = 0; m_frame[k] = 0; m_tv[k] = 1'b1;
                        end
                    end
                endcase
            end
            e_sa[k] = (m_mode[k] != M_DONE);
        end
        if (!rst_n) begin
            pl = 1'b0; pr = 1'b0; ps = 1'b0;
        end else begin
            pl = btn_left; pr = btn_right; ps = btn_start;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (sg5 || sg8) saw_sg = 1'b1;
        check("pix5", pix5, e_pix[0]);
        check("sel5", {13'd0, sel5}, 16'(m_sel[0]));
        check("sg5", {15'd0, sg5}, {15'd0, e_sg[0]});
        check("sa5", {15'd0, sa5}, {15'd0, e_sa[0]});
        check("pix8", pix8, e_pix[1]);
        check("sel8", {13'd0, sel8}, 16'(m_sel[1]));
        check("sg8", {15'd0, sg8}, {15'd0, e_sg[1]});
        check("sa8", {15'd0, sa8}, {15'd0, e_sa[1]});
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat (gap) step();
        end
    endtask

    // which: 0 left, 1 right, 2 start, 3 left+right together
    task automatic press(input int which);
        btn_left  = (which == 0 || which == 3);
        btn_right = (which == 1 || which == 3);
        btn_start = (which == 2);
        step();
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; title_px = 1'b0; restart = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
        x = 7'd3; y = 6'd10;
        pl = 1'b0; pr = 1'b0; ps = 1'b0;

        repeat (2) step();
        check("rst_pix", pix5, 16'h0000);
        check("rst_sel", {13'd0, sel5}, 16'd0);
        check("rst_sa", {15'd0, sa5}, 16'd1);

        rst_n = 1'b1;
        step();
        check("attract_wire0", pix5, 16'hFC0D);
        title_px = 1'b1;
        step();
        check("title_on", pix5, 16'hFFFF);
        ticks(30, 9);
        check("title_off_30", pix5, 16'hFC0D);
        ticks(30, 9);
        check("title_on_60", pix5, 16'hFFFF);
        title_px = 1'b0;

        press(1);
        check("enter_select_sel", {13'd0, sel5}, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            press(1);
            check("right_wrap", {13'd0, sel5}, 16'(i % 5));
        end
        press(0);
        check("left_wrap", {13'd0, sel5}, 16'd4);
        press(3);
        check("lr_cancel", {13'd0, sel5}, 16'd4);
        repeat (3) press(1);
        check("sel_is_2", {13'd0, sel5}, 16'd2);

        x = 7'd15; y = 6'd60; step();
        check("cursor_px", pix5, 16'hFFFF);
        x = 7'd15; y = 6'd20; step();
        check("wire2_px", pix5, 16'h001F);
        x = 7'd9; y = 6'd60; step();
        check("wire1_low", pix5, 16'hF800);

        press(0);
        press(2);
        x = 7'd9; y = 6'd20; step();
        check("flash_on0", pix5, 16'hF800);
        ticks(4, 3);
        check("flash_off", pix5, 16'h0000);
        ticks(4, 3);
        check("flash_on8", pix5, 16'hF800);
        press(1);
        check("confirm_ignore", {13'd0, sel5}, 16'd1);
        ticks(7, 3);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("start_pulse", {15'd0, sg5}, 16'd1);
        step();
        check("start_once", {15'd0, sg5}, 16'd0);
        check("done_inactive", {15'd0, sa5}, 16'd0);
        check("done_black", pix5, 16'h0000);
        press(0);
        check("done_ignore", {13'd0, sel5}, 16'd1);

        restart = 1'b1; step(); restart = 1'b0; step();
        check("restart_active", {15'd0, sa5}, 16'd1);
        x = 7'd45; y = 6'd20; step();
        check("wire7_px", pix8, 16'h801F);

        press(1);
        press(2);
        ticks(10, 3);
        saw_sg = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("midrst_sel", {13'd0, sel5}, 16'd0);
        check("midrst_sa", {15'd0, sa5}, 16'd1);
        ticks(20, 3);
        check("midrst_no_pulse", {15'd0, saw_sg}, 16'd0);

        press(1);
        press(0);
        check("sel8_wrap7", {13'd0, sel8}, 16'd7);

        for (int c = 0; c < 4000; c++) begin
            x          = 7'($urandom_range(0, 127));
            y          = 6'($urandom);
            title_px   = ($urandom % 4 == 0);
            frame_tick = ($urandom % 6 == 0);
            if ($urandom % 8 == 0) btn_left  = !btn_left;
            if ($urandom % 8 == 0) btn_right = !btn_right;
            if ($urandom % 10 == 0) btn_start = !btn_start;
            restart = ($urandom % 40 == 0);
            rst_n   = ($urandom % 700 != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
